// File: rtl/ltest_occ_sequencer.sv
// rtl/ltest_occ_sequencer.sv - On-chip clock capture-burst sequencer for logic test.
module ltest_occ_sequencer #(
    parameter int PATTERN_W   = 4,
    parameter int SYNC_CYCLES = 2
) (
    input  logic       ltest_clk_buf,
    input  logic       ijtag_reset,
    input  logic       ltest_en,
    input  logic       ltest_scan_en,
    input  logic       ltest_occ_en,
    input  logic       ltest_static_clock_control_mode,
    input  logic [1:0] ltest_clock_sequence,
    input  logic       ltest_si,
    output logic       ltest_so,
    output logic       occ_fe,
    output logic       occ_busy,
    output logic       occ_done,
    output logic       occ_abort,
    output logic [3:0] occ_pulse_count
);

    typedef enum logic [1:0] {IDLE, SYNC, FIRE, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(SYNC_CYCLES - 1);
    localparam logic [3:0] LAST_SLOT = 4'(PATTERN_W - 1);

    state_t                 state_q, state_d;
    logic [PATTERN_W-1:0]   pattern_q, pattern_d;
    logic                   scan_en_q;
    logic [3:0]             wait_q, wait_d;
    logic [3:0]             slot_q, slot_d;
    logic [3:0]             count_q, count_d;
    logic                   fe_q, fe_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   abort_req;
    logic                   emit;

    assign abort_req = ltest_scan_en | ~ltest_en;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        wait_d    = wait_q;
        slot_d    = slot_q;
        count_d   = count_q;
        fe_d      = 1'b0;
        done_d    = 1'b0;
        abort_d   = abort_q;
        emit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_en_q && !ltest_scan_en && ltest_en && ltest_occ_en) begin
                    state_d = SYNC;
                    count_d = 4'd0;
                    abort_d = 1'b0;
                    wait_d  = WAIT_INIT;
                end else if (ltest_scan_en) begin
                    if (ltest_static_clock_control_mode) begin
                        pattern_d      = '0;
                        pattern_d[1:0] = ltest_clock_sequence;
                    end else begin
                        pattern_d = {ltest_si, pattern_q[PATTERN_W-1:1]};
                    end
                end
            end
            SYNC: begin
                if (abort_req) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (wait_q == 4'd0) begin
                    // Slot 0 is launched on the same edge that enters FIRE.
                    state_d = FIRE;
                    slot_d  = 4'd0;
                    emit    = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            FIRE: begin
                if (abort_req) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (slot_q == LAST_SLOT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    slot_d = slot_q + 4'd1;
                    emit   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit) begin
            fe_d      = pattern_q[0];
            pattern_d = {1'b0, pattern_q[PATTERN_W-1:1]};
            if (pattern_q[0] && (count_q != 4'd15)) begin
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge ltest_clk_buf or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            scan_en_q <= 1'b0;
            wait_q    <= 4'd0;
            slot_q    <= 4'd0;
            count_q   <= 4'd0;
            fe_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            scan_en_q <= ltest_scan_en;
            wait_q    <= wait_d;
            slot_q    <= slot_d;
            count_q   <= count_d;
            fe_q      <= fe_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // Static load passes scan data straight through so the chain stays intact.
    assign ltest_so = (state_q == IDLE && ltest_scan_en && ltest_static_clock_control_mode)
                      ? ltest_si : pattern_q[0];

    assign occ_busy        = (state_q == SYNC) || (state_q == FIRE);
    assign occ_fe          = fe_q;
    assign occ_done        = done_q;
    assign occ_abort       = abort_q;
    assign occ_pulse_count = count_q;

endmodule

// File: tb/tb_ltest_occ_sequencer.sv
// tb/tb_ltest_occ_sequencer.sv - Scoreboard bench for ltest_occ_sequencer.
module tb_ltest_occ_sequencer;

    logic       ltest_clk_buf = 1'b0;
    logic       ijtag_reset;
    logic       ltest_en;
    logic       ltest_scan_en;
    logic       ltest_occ_en;
    logic       ltest_static_clock_control_mode;
    logic [1:0] ltest_clock_sequence;
    logic       ltest_si;
    logic       ltest_so;
    logic       occ_fe;
    logic       occ_busy;
    logic       occ_done;
    logic       occ_abort;
    logic [3:0] occ_pulse_count;

    always #5 ltest_clk_buf = ~ltest_clk_buf;

    ltest_occ_sequencer #(.PATTERN_W(4), .SYNC_CYCLES(2)) dut (
        .ltest_clk_buf                   (ltest_clk_buf),
        .ijtag_reset                     (ijtag_reset),
        .ltest_en                        (ltest_en),
        .ltest_scan_en                   (ltest_scan_en),
        .ltest_occ_en                    (ltest_occ_en),
        .ltest_static_clock_control_mode (ltest_static_clock_control_mode),
        .ltest_clock_sequence            (ltest_clock_sequence),
        .ltest_si                        (ltest_si),
        .ltest_so                        (ltest_so),
        .occ_fe                          (occ_fe),
        .occ_busy                        (occ_busy),
        .occ_done                        (occ_done),
        .occ_abort                       (occ_abort),
        .occ_pulse_count                 (occ_pulse_count)
    );

    typedef struct {
        logic [31:0] hist;
        int          n;
        logic [3:0]  cnt;
        logic        done;
        logic        abort;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] hist, input int n, input logic [3:0] cnt,
                        input logic done, input logic abort);
        exp_t e;
        e.hist  = hist;
        e.n     = n;
        e.cnt   = cnt;
        e.done  = done;
        e.abort = abort;
        sbq.push_back(e);
    endtask

    // Busy-window monitor: fe trace per busy cycle, outcome judged on the first non-busy cycle.
    logic [31:0] m_hist = '0;
    int          m_n    = 0;
    bit          m_in   = 1'b0;
    exp_t        m_e;

    always @(negedge ltest_clk_buf) begin
        if (!ijtag_reset) begin
            m_in   = 1'b0;
            m_hist = '0;
            m_n    = 0;
        end else if (occ_busy) begin
            m_hist = {m_hist[30:0], occ_fe};
            m_n    = m_n + 1;
            m_in   = 1'b1;
        end else if (m_in) begin
            m_in = 1'b0;
            if (sbq.size() == 0) begin
                chk("unexpected_burst", 32'd1, 32'd0);
            end else begin
                m_e = sbq.pop_front();
                chk("fe_trace", m_hist, m_e.hist);
                chk("busy_cycles", m_n, m_e.n);
                chk("pulse_count", {28'd0, occ_pulse_count}, {28'd0, m_e.cnt});
                chk("done", {31'd0, occ_done}, {31'd0, m_e.done});
                chk("abort", {31'd0, occ_abort}, {31'd0, m_e.abort});
            end
            m_hist = '0;
            m_n    = 0;
        end
    end

    task automatic tick();
        @(posedge ltest_clk_buf);
        #1;
    endtask

    task automatic shift4(input logic [3:0] v);
        ltest_static_clock_control_mode = 1'b0;
        ltest_scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ltest_si = v[i];
            tick();
        end
        ltest_si = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 40) begin
            tick();
            t++;
        end
        chk("drain_timeout", sbq.size(), 32'd0);
        tick();
        chk("done_single", {31'd0, occ_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        ijtag_reset = 1'b1;
        ltest_en = 1'b1;
        ltest_scan_en = 1'b0;
        ltest_occ_en = 1'b1;
        ltest_static_clock_control_mode = 1'b0;
        ltest_clock_sequence = 2'b00;
        ltest_si = 1'b0;
        #1 ijtag_reset = 1'b0;
        #1;
        chk("rst_fe", {31'd0, occ_fe}, 32'd0);
        chk("rst_busy", {31'd0, occ_busy}, 32'd0);
        chk("rst_done", {31'd0, occ_done}, 32'd0);
        chk("rst_abort", {31'd0, occ_abort}, 32'd0);
        chk("rst_count", {28'd0, occ_pulse_count}, 32'd0);
        chk("rst_so", {31'd0, ltest_so}, 32'd0);
        tick();
        tick();
        ijtag_reset = 1'b1;
        tick();

        // Shifted pattern 1011: two sync cycles then slots 1,1,0,1.
        push(32'b001101, 6, 4'd3, 1'b1, 1'b0);
        shift4(4'b1011);
        ltest_scan_en = 1'b0;
        drain();

        // Static load 2'b10 with scan-in bypass.
        ltest_static_clock_control_mode = 1'b1;
        ltest_clock_sequence = 2'b10;
        ltest_scan_en = 1'b1;
        ltest_si = 1'b1;
        #1 chk("bypass_so_1", {31'd0, ltest_so}, 32'd1);
        ltest_si = 1'b0;
        #1 chk("bypass_so_0", {31'd0, ltest_so}, 32'd0);
        tick();
        push(32'b000100, 6, 4'd1, 1'b1, 1'b0);
        ltest_scan_en = 1'b0;
        drain();
        ltest_static_clock_control_mode = 1'b0;

        // Abort by raising scan_en while slot 0 is on occ_fe.
        push(32'b001, 3, 4'd1, 1'b0, 1'b1);
        shift4(4'b1111);
        ltest_scan_en = 1'b0;
        tick();
        tick();
        tick();
        ltest_scan_en = 1'b1;
        drain();

        // Fall with OCC disabled is ignored and flags persist.
        ltest_occ_en = 1'b0;
        tick();
        ltest_scan_en = 1'b0;
        repeat (6) tick();
        chk("noocc_busy", {31'd0, occ_busy}, 32'd0);
        chk("noocc_fe", {31'd0, occ_fe}, 32'd0);
        chk("noocc_abort", {31'd0, occ_abort}, 32'd1);
        chk("noocc_count", {28'd0, occ_pulse_count}, 32'd1);
        ltest_occ_en = 1'b1;

        // All-zero pattern still runs the full burst.
        push(32'b000000, 6, 4'd0, 1'b1, 1'b0);
        shift4(4'b0000);
        ltest_scan_en = 1'b0;
        drain();

        // Reset asserted while firing.
        shift4(4'b1111);
        ltest_scan_en = 1'b0;
        tick();
        tick();
        tick();
        chk("prereset_fe", {31'd0, occ_fe}, 32'd1);
        ijtag_reset = 1'b0;
        #1;
        chk("midrst_fe", {31'd0, occ_fe}, 32'd0);
        chk("midrst_busy", {31'd0, occ_busy}, 32'd0);
        chk("midrst_done", {31'd0, occ_done}, 32'd0);
        chk("midrst_abort", {31'd0, occ_abort}, 32'd0);
        chk("midrst_count", {28'd0, occ_pulse_count}, 32'd0);
        tick();
        tick();
        ijtag_reset = 1'b1;
        repeat (5) tick();
        chk("postrst_busy", {31'd0, occ_busy}, 32'd0);
        chk("postrst_fe", {31'd0, occ_fe}, 32'd0);

        // ltest_en drop during SYNC aborts before any slot.
        push(32'b0, 1, 4'd0, 1'b0, 1'b1);
        shift4(4'b1111);
        ltest_scan_en = 1'b0;
        tick();
        ltest_en = 1'b0;
        drain();
        ltest_en = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ltest_occ_sequencer.md
LTEST_OCC_SEQUENCER -- requirements
Module: ltest_occ_sequencer

Interface
REQ-001 SHALL have parameter PATTERN_W, default 4, number of capture slots per burst (legal 2..15).
REQ-002 SHALL have parameter SYNC_CYCLES, default 2, idle cycles between the scan_en fall and slot 0 (legal 1..15).
REQ-003 SHALL have ports as follows (clock and reset first):
- ltest_clk_buf  in  1  sequencer clock, all flops on rising edge.
- ijtag_reset  in  1  reset, asynchronous, active-low.
- ltest_en  in  1  logic-test mode enable.
- ltest_scan_en  in  1  scan shift enable.
- ltest_occ_en  in  1  OCC capture enable.
- ltest_static_clock_control_mode  in  1  static pattern select.
- ltest_clock_sequence  in  2  static capture pattern.
- ltest_si  in  1  pattern scan-in.
- ltest_so  out  1  pattern scan-out.
- occ_fe  out  1  registered functional enable to the OCC clock gate.
- occ_busy  out  1  burst in progress.
- occ_done  out  1  one-cycle burst-complete pulse.
- occ_abort  out  1  sticky flag, last burst aborted.
- occ_pulse_count  out  4  occ_fe-high cycles in current/last burst.

Function
REQ-004 SHALL implement FSM states IDLE, SYNC, FIRE, DONE; occ_busy = (SYNC or FIRE), combinational from state.
REQ-005 IDLE, ltest_scan_en=1, static mode=0: pattern[PATTERN_W-1:0] <= {ltest_si, pattern[PATTERN_W-1:1]}; ltest_so = pattern[0].
REQ-006 IDLE, ltest_scan_en=1, static mode=1: pattern <= zero-extended ltest_clock_sequence; ltest_so = ltest_si (combinational bypass).
REQ-007 Pattern SHALL hold whenever the shift/load conditions of REQ-005/006 are false outside FIRE.
REQ-008 Trigger: at edge E0 where scan_en_q=1, ltest_scan_en=0, state IDLE, ltest_en=1, ltest_occ_en=1 -> SYNC; occ_pulse_count <= 0; occ_abort <= 0; wait counter <= SYNC_CYCLES-1.
REQ-009 scan_en_q SHALL be ltest_scan_en registered every cycle.
REQ-010 Falling edge with ltest_en=0 or ltest_occ_en=0 SHALL be ignored (remain IDLE, no flag change).
REQ-011 SYNC: decrement wait counter; enter FIRE at edge E0+SYNC_CYCLES with slot counter <= 0.
REQ-012 FIRE, each edge: occ_fe <= pattern[0]; pattern <= {1'b0, pattern[PATTERN_W-1:1]}; occ_pulse_count += pattern[0], saturating at 15; slot counter += 1.
REQ-013 Slot k SHALL appear on occ_fe in the cycle following edge E0+SYNC_CYCLES+k, k=0..PATTERN_W-1.
REQ-014 At edge E0+SYNC_CYCLES+PATTERN_W: state DONE, occ_fe <= 0, occ_done <= 1; next edge: IDLE, occ_done <= 0.
REQ-015 All-zero pattern SHALL still run full burst; occ_pulse_count=0; occ_done pulses.
REQ-016 Abort: ltest_scan_en=1 or ltest_en=0 sampled in SYNC or FIRE -> IDLE next edge; occ_fe <= 0; occ_abort <= 1; no occ_done; occ_pulse_count holds.
REQ-017 Abort takes priority over the FIRE->DONE transition in the same cycle.
REQ-018 Shift/load (REQ-005/006) SHALL NOT occur in SYNC, FIRE or DONE; the abort edge itself performs no shift.
REQ-019 occ_fe SHALL be 0 in every state other than FIRE-driven cycles.

Reset
REQ-020 ijtag_reset=0 SHALL asynchronously force state IDLE, pattern 0, scan_en_q 0, counters 0, occ_fe 0, occ_done 0, occ_abort 0, occ_pulse_count 0.
REQ-021 ltest_scan_en=0 at reset release SHALL NOT trigger; one high sample first is required.
REQ-022 Reset assertion mid-burst SHALL take effect immediately with no occ_done.

Verification
REQ-023 Shift 4'b1011 (LSB first), drop scan_en -> occ_fe 1,1,0,1 in cycles E0+3..E0+6, occ_pulse_count=3, occ_done at E0+7.
REQ-024 Static mode, ltest_clock_sequence=2'b10, fall -> occ_fe 0,1,0,0, count=1; ltest_so follows ltest_si during load.
REQ-025 Raise scan_en at slot 1 of 4'b1111 -> IDLE, occ_fe 0 next cycle, occ_abort=1, count=1, no occ_done.
REQ-026 Fall with ltest_occ_en=0 -> no busy, occ_fe stays 0, flags unchanged.
REQ-027 Assert ijtag_reset in FIRE -> all outputs 0 immediately; release with scan_en=0 -> no burst.
REQ-028 Pattern 4'b0000 -> 4 FIRE cycles, occ_fe never 1, count=0, occ_done pulses once.
